// File: rtl/int_regfile_param_if.sv
// ---------------------------------------------------------------------------
// int_regfile_param_if
// Bundles the register-file bus: two read ports, the writeback port, the
// scoreboard issue port and the trap/mret control with its captured CSRs.
//   master : the pipeline side (drives addresses, writeback, issue, trap)
//   slave  : the register file itself
// Clock and reset are not part of this bundle; they stay plain module ports.
// ---------------------------------------------------------------------------
interface int_regfile_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    // read ports
    logic [ADDR_W-1:0] read_addr_a_i;
    logic [ADDR_W-1:0] read_addr_b_i;
    logic [DATA_W-1:0] read_data_a_o;
    logic [DATA_W-1:0] read_data_b_o;
    // writeback
    logic              write_enable_i;
    logic [ADDR_W-1:0] write_addr_i;
    logic [DATA_W-1:0] write_data_i;
    // scoreboard
    logic              issue_valid_i;
    logic [ADDR_W-1:0] issue_addr_i;
    logic              busy_a_o;
    logic              busy_b_o;
    // trap control
    logic              trap_i;
    logic [DATA_W-1:0] trap_pc_i;
    logic [DATA_W-1:0] trap_cause_i;
    logic [DATA_W-1:0] trap_val_i;
    logic              mret_i;
    logic [DATA_W-1:0] mepc_o;
    logic [DATA_W-1:0] mcause_o;
    logic [DATA_W-1:0] mtval_o;
    logic              trap_active_o;
    logic              double_fault_o;

    modport master (
        output read_addr_a_i, read_addr_b_i,
        input  read_data_a_o, read_data_b_o,
        output write_enable_i, write_addr_i, write_data_i,
        output issue_valid_i, issue_addr_i,
        input  busy_a_o, busy_b_o,
        output trap_i, trap_pc_i, trap_cause_i, trap_val_i, mret_i,
        input  mepc_o, mcause_o, mtval_o, trap_active_o, double_fault_o
    );

    modport slave (
        input  read_addr_a_i, read_addr_b_i,
        output read_data_a_o, read_data_b_o,
        input  write_enable_i, write_addr_i, write_data_i,
        input  issue_valid_i, issue_addr_i,
        output busy_a_o, busy_b_o,
        input  trap_i, trap_pc_i, trap_cause_i, trap_val_i, mret_i,
        output mepc_o, mcause_o, mtval_o, trap_active_o, double_fault_o
    );
endinterface

// File: rtl/int_regfile_param.sv
// ---------------------------------------------------------------------------
// int_regfile_param
// Integer register file with two combinational read ports, write-through
// bypass, a per-register pending scoreboard and a two-state trap FSM that
// captures mepc/mcause/mtval.
// Ports:
//   clk_i  : clock, rising edge
//   rsn_i  : asynchronous active-low reset
//   rf     : int_regfile_param_if.slave (read/write/issue/trap bus)
// Parameters:
//   DATA_W   : register and trap-data width
//   ADDR_W   : register address width (depth 2^ADDR_W)
//   ZERO_REG : 1 -> register 0 is hardwired to zero, never pending
// ---------------------------------------------------------------------------
module int_regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    int_regfile_param_if.slave   rf
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE = 1'b0, TRAP = 1'b1} state_t;

    state_t            state_reg;
    logic [DATA_W-1:0] mepc_reg;
    logic [DATA_W-1:0] mcause_reg;
    logic [DATA_W-1:0] mtval_reg;
    logic              trap_active_reg;
    logic              double_fault_reg;

    logic [DATA_W-1:0] reg_array [DEPTH];
    logic [DEPTH-1:0]  pending;

    // Inputs are ignored while reset is held, which also keeps the bypass
    // path from leaking write data onto the read ports during reset.
    logic wr_valid;
    logic trap_take;
    assign wr_valid  = rf.write_enable_i & rsn_i;
    // Taking a trap flushes the scoreboard and drops a same-cycle issue.
    assign trap_take = (state_reg == IDLE) & rf.trap_i;

    // -----------------------------------------------------------------------
    // Storage and scoreboard, one slice per register
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
            localparam bit IS_ZERO = (ZERO_REG != 0) && (gi == 0);

            logic [DATA_W-1:0] word_reg;
            logic              pend_reg;
            logic              wr_hit;
            logic              iss_hit;

            assign wr_hit  = rf.write_enable_i && (rf.write_addr_i == ADDR_W'(gi)) && !IS_ZERO;
            assign iss_hit = rf.issue_valid_i  && (rf.issue_addr_i == ADDR_W'(gi)) && !IS_ZERO;

            always_ff @(posedge clk_i or negedge rsn_i) begin
                if (!rsn_i) begin
                    word_reg <= '0;
                    pend_reg <= 1'b0;
                end else begin
                    // writes land even in the cycle a trap is taken
                    if (wr_hit)
                        word_reg <= rf.write_data_i;
                    // set beats clear: a same-cycle new producer stays pending
                    if (trap_take)
                        pend_reg <= 1'b0;
                    else if (iss_hit)
                        pend_reg <= 1'b1;
                    else if (wr_hit)
                        pend_reg <= 1'b0;
                end
            end

            assign reg_array[gi] = word_reg;
            assign pending[gi]   = pend_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Read ports with write-through bypass
    // -----------------------------------------------------------------------
    logic a_is_zero, b_is_zero, a_bypass, b_bypass;
    assign a_is_zero = (ZERO_REG != 0) && (rf.read_addr_a_i == '0);
    assign b_is_zero = (ZERO_REG != 0) && (rf.read_addr_b_i == '0);
    assign a_bypass  = wr_valid && (rf.write_addr_i == rf.read_addr_a_i);
    assign b_bypass  = wr_valid && (rf.write_addr_i == rf.read_addr_b_i);

    assign rf.read_data_a_o = a_is_zero ? '0 :
                              a_bypass  ? rf.write_data_i : reg_array[rf.read_addr_a_i];
    assign rf.read_data_b_o = b_is_zero ? '0 :
                              b_bypass  ? rf.write_data_i : reg_array[rf.read_addr_b_i];

    // A bypassed operand is available now, so it is not busy.
    assign rf.busy_a_o = pending[rf.read_addr_a_i] & ~a_bypass;
    assign rf.busy_b_o = pending[rf.read_addr_b_i] & ~b_bypass;

    // -----------------------------------------------------------------------
    // Trap FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_reg        <= IDLE;
            mepc_reg         <= '0;
            mcause_reg       <= '0;
            mtval_reg        <= '0;
            trap_active_reg  <= 1'b0;
            double_fault_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // mret here has nothing to return from
                    if (rf.trap_i) begin
                        state_reg       <= TRAP;
                        trap_active_reg <= 1'b1;
                        mepc_reg        <= rf.trap_pc_i;
                        mcause_reg      <= rf.trap_cause_i;
                        mtval_reg       <= rf.trap_val_i;
                    end
                end
                TRAP: begin
                    // a nested trap wins over mret and keeps the first capture
                    if (rf.trap_i) begin
                        double_fault_reg <= 1'b1;
                    end else if (rf.mret_i) begin
                        state_reg       <= IDLE;
                        trap_active_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg       <= IDLE;
                    trap_active_reg <= 1'b0;
                end
            endcase
        end
    end

    assign rf.mepc_o         = mepc_reg;
    assign rf.mcause_o       = mcause_reg;
    assign rf.mtval_o        = mtval_reg;
    assign rf.trap_active_o  = trap_active_reg;
    assign rf.double_fault_o = double_fault_reg;

endmodule

// File: tb/tb_int_regfile_param.sv
// ---------------------------------------------------------------------------
// tb_int_regfile_param
// Directed bench for int_regfile_param: reset state, bypass, zero register,
// scoreboard set/clear priority, trap capture, double fault and async reset.
// Inputs change 1 time unit after a rising edge; outputs are checked before
// the next rising edge.
// ---------------------------------------------------------------------------
module tb_int_regfile_param;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic clk;
    logic rsn;
    int   tests;
    int   fails;

    int_regfile_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rf_if ();

    int_regfile_param #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(1)
    ) dut (
        .clk_i(clk),
        .rsn_i(rsn),
        .rf   (rf_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rsn = 1'b0;
        rf_if.read_addr_a_i  = '0;
        rf_if.read_addr_b_i  = '0;
        rf_if.write_enable_i = 1'b0;
        rf_if.write_addr_i   = '0;
        rf_if.write_data_i   = '0;
        rf_if.issue_valid_i  = 1'b0;
        rf_if.issue_addr_i   = '0;
        rf_if.trap_i         = 1'b0;
        rf_if.trap_pc_i      = '0;
        rf_if.trap_cause_i   = '0;
        rf_if.trap_val_i     = '0;
        rf_if.mret_i         = 1'b0;

        // ---- reset state (before any clock edge) ----
        #2;
        check("rst_rda",    rf_if.read_data_a_o, 32'h0);
        check("rst_mepc",   rf_if.mepc_o, 32'h0);
        check("rst_active", {31'b0, rf_if.trap_active_o}, 32'h0);
        check("rst_df",     {31'b0, rf_if.double_fault_o}, 32'h0);
        tick();
        tick();
        rsn = 1'b1;

        // ---- write x5, same-cycle bypass on port B, next-cycle read on A ----
        rf_if.write_enable_i = 1'b1;
        rf_if.write_addr_i   = 5'd5;
        rf_if.write_data_i   = 32'hDEADBEEF;
        rf_if.read_addr_b_i  = 5'd5;
        #1;
        check("bypass_b_x5", rf_if.read_data_b_o, 32'hDEADBEEF);
        tick();
        rf_if.write_enable_i = 1'b0;
        rf_if.read_addr_a_i  = 5'd5;
        #1;
        check("read_a_x5", rf_if.read_data_a_o, 32'hDEADBEEF);

        // ---- zero register ----
        rf_if.write_enable_i = 1'b1;
        rf_if.write_addr_i   = 5'd0;
        rf_if.write_data_i   = 32'h1234;
        rf_if.read_addr_a_i  = 5'd0;
        #1;
        check("x0_no_bypass", rf_if.read_data_a_o, 32'h0);
        tick();
        rf_if.write_enable_i = 1'b0;
        #1;
        check("x0_read", rf_if.read_data_a_o, 32'h0);
        rf_if.issue_valid_i = 1'b1;
        rf_if.issue_addr_i  = 5'd0;
        tick();
        rf_if.issue_valid_i = 1'b0;
        #1;
        check("x0_busy", {31'b0, rf_if.busy_a_o}, 32'h0);

        // ---- scoreboard on x7 ----
        rf_if.issue_valid_i = 1'b1;
        rf_if.issue_addr_i  = 5'd7;
        tick();
        rf_if.issue_valid_i = 1'b0;
        rf_if.read_addr_a_i = 5'd7;
        rf_if.read_addr_b_i = 5'd5;
        #1;
        check("x7_busy", {31'b0, rf_if.busy_a_o}, 32'h1);
        check("x5_not_busy", {31'b0, rf_if.busy_b_o}, 32'h0);
        rf_if.write_enable_i = 1'b1;
        rf_if.write_addr_i   = 5'd7;
        rf_if.write_data_i   = 32'h55;
        #1;
        check("x7_wb_busy", {31'b0, rf_if.busy_a_o}, 32'h0);
        check("x7_wb_data", rf_if.read_data_a_o, 32'h55);
        tick();
        rf_if.write_enable_i = 1'b0;
        #1;
        check("x7_cleared", {31'b0, rf_if.busy_a_o}, 32'h0);
        check("x7_stored", rf_if.read_data_a_o, 32'h55);
        rf_if.issue_valid_i  = 1'b1;
        rf_if.issue_addr_i   = 5'd7;
        rf_if.write_enable_i = 1'b1;
        rf_if.write_addr_i   = 5'd7;
        rf_if.write_data_i   = 32'h66;
        tick();
        rf_if.issue_valid_i  = 1'b0;
        rf_if.write_enable_i = 1'b0;
        #1;
        check("x7_set_wins", {31'b0, rf_if.busy_a_o}, 32'h1);
        check("x7_data_66", rf_if.read_data_a_o, 32'h66);

        // ---- trap capture; same-cycle issue dropped, same-cycle write kept ----
        rf_if.trap_i         = 1'b1;
        rf_if.trap_pc_i      = 32'h100;
        rf_if.trap_cause_i   = 32'h2;
        rf_if.trap_val_i     = 32'hBAD;
        rf_if.issue_valid_i  = 1'b1;
        rf_if.issue_addr_i   = 5'd3;
        rf_if.write_enable_i = 1'b1;
        rf_if.write_addr_i   = 5'd4;
        rf_if.write_data_i   = 32'hAA;
        #1;
        check("trap_not_yet", {31'b0, rf_if.trap_active_o}, 32'h0);
        tick();
        rf_if.trap_i         = 1'b0;
        rf_if.issue_valid_i  = 1'b0;
        rf_if.write_enable_i = 1'b0;
        rf_if.read_addr_a_i  = 5'd7;
        rf_if.read_addr_b_i  = 5'd3;
        #1;
        check("trap_mepc",   rf_if.mepc_o, 32'h100);
        check("trap_mcause", rf_if.mcause_o, 32'h2);
        check("trap_mtval",  rf_if.mtval_o, 32'hBAD);
        check("trap_active", {31'b0, rf_if.trap_active_o}, 32'h1);
        check("trap_x7_flushed", {31'b0, rf_if.busy_a_o}, 32'h0);
        check("trap_x3_dropped", {31'b0, rf_if.busy_b_o}, 32'h0);
        rf_if.read_addr_a_i = 5'd4;
        #1;
        check("trap_x4_written", rf_if.read_data_a_o, 32'hAA);
        rf_if.mret_i = 1'b1;
        tick();
        rf_if.mret_i = 1'b0;
        #1;
        check("mret_idle", {31'b0, rf_if.trap_active_o}, 32'h0);
        check("mret_mepc_hold", rf_if.mepc_o, 32'h100);
        rf_if.mret_i = 1'b1;
        tick();
        rf_if.mret_i = 1'b0;
        #1;
        check("mret_in_idle", {31'b0, rf_if.trap_active_o}, 32'h0);

        // ---- double fault ----
        rf_if.trap_i       = 1'b1;
        rf_if.trap_pc_i    = 32'h100;
        rf_if.trap_cause_i = 32'h2;
        rf_if.trap_val_i   = 32'hBAD;
        tick();
        rf_if.trap_pc_i    = 32'h200;
        rf_if.trap_cause_i = 32'h3;
        rf_if.trap_val_i   = 32'hCAFE;
        rf_if.mret_i       = 1'b1;
        tick();
        rf_if.trap_i = 1'b0;
        rf_if.mret_i = 1'b0;
        #1;
        check("df_mepc_hold",   rf_if.mepc_o, 32'h100);
        check("df_mcause_hold", rf_if.mcause_o, 32'h2);
        check("df_set",         {31'b0, rf_if.double_fault_o}, 32'h1);
        check("df_still_trap",  {31'b0, rf_if.trap_active_o}, 32'h1);
        rf_if.mret_i = 1'b1;
        tick();
        rf_if.mret_i = 1'b0;
        #1;
        check("df_mret_idle", {31'b0, rf_if.trap_active_o}, 32'h0);
        rf_if.trap_i = 1'b1;
        tick();
        rf_if.trap_i = 1'b0;
        #1;
        check("df_recapture_pc",    rf_if.mepc_o, 32'h200);
        check("df_recapture_cause", rf_if.mcause_o, 32'h3);
        check("df_recapture_val",   rf_if.mtval_o, 32'hCAFE);
        check("df_sticky",          {31'b0, rf_if.double_fault_o}, 32'h1);

        // ---- async reset mid-trap ----
        rf_if.issue_valid_i = 1'b1;
        rf_if.issue_addr_i  = 5'd8;
        tick();
        rf_if.issue_valid_i = 1'b0;
        rf_if.read_addr_a_i = 5'd5;
        rf_if.read_addr_b_i = 5'd8;
        #1;
        check("pre_rst_busy8", {31'b0, rf_if.busy_b_o}, 32'h1);
        #1;
        rsn = 1'b0;
        #1;
        check("arst_rda",    rf_if.read_data_a_o, 32'h0);
        check("arst_busy",   {31'b0, rf_if.busy_b_o}, 32'h0);
        check("arst_mepc",   rf_if.mepc_o, 32'h0);
        check("arst_mcause", rf_if.mcause_o, 32'h0);
        check("arst_mtval",  rf_if.mtval_o, 32'h0);
        check("arst_active", {31'b0, rf_if.trap_active_o}, 32'h0);
        check("arst_df",     {31'b0, rf_if.double_fault_o}, 32'h0);
        // inputs held during reset must be ignored
        rf_if.write_enable_i = 1'b1;
        rf_if.write_addr_i   = 5'd6;
        rf_if.write_data_i   = 32'h77;
        rf_if.trap_i         = 1'b1;
        rf_if.issue_valid_i  = 1'b1;
        rf_if.issue_addr_i   = 5'd6;
        rf_if.read_addr_a_i  = 5'd6;
        #1;
        check("rst_no_bypass", rf_if.read_data_a_o, 32'h0);
        tick();
        tick();
        rf_if.write_enable_i = 1'b0;
        rf_if.trap_i         = 1'b0;
        rf_if.issue_valid_i  = 1'b0;
        rsn = 1'b1;
        #1;
        check("post_rst_x6",     rf_if.read_data_a_o, 32'h0);
        check("post_rst_busy6",  {31'b0, rf_if.busy_a_o}, 32'h0);
        check("post_rst_active", {31'b0, rf_if.trap_active_o}, 32'h0);
        rf_if.read_addr_a_i = 5'd5;
        rf_if.read_addr_b_i = 5'd7;
        #1;
        check("post_rst_x5", rf_if.read_data_a_o, 32'h0);
        check("post_rst_x7", rf_if.read_data_b_o, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/int_regfile_param.md
INT_REGFILE_PARAM -- requirements
Module: int_regfile_param

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- DATA_W, 32, register and trap-data width in bits.
- ADDR_W, 5, register address width; depth is 2^ADDR_W.
- ZERO_REG, 1, when 1, register 0 reads 0 and ignores writes and issues.

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk_i, in, 1, sole clock; rising edge.
- rsn_i, in, 1, reset; asynchronous, active-low.
- read_addr_a_i / read_addr_b_i, in, ADDR_W, read port A/B address.
- read_data_a_o / read_data_b_o, out, DATA_W, read port A/B data.
- write_enable_i, in, 1, writeback valid.
- write_addr_i, in, ADDR_W, writeback register.
- write_data_i, in, DATA_W, writeback data.
- issue_valid_i, in, 1, an instruction with destination issue_addr_i issued.
- issue_addr_i, in, ADDR_W, destination register to mark pending.
- busy_a_o / busy_b_o, out, 1, the port A/B operand is still pending.
- trap_i, in, 1, exception request.
- trap_pc_i / trap_cause_i / trap_val_i, in, DATA_W, exception PC, cause and value.
- mret_i, in, 1, return from exception.
- mepc_o / mcause_o / mtval_o, out, DATA_W, captured trap registers.
- trap_active_o, out, 1, handler in progress.
- double_fault_o, out, 1, sticky flag for a trap taken while already in a trap.

Function
REQ-003 Reads SHALL be combinational from the register array, using the current-cycle address.
REQ-004 Write-through bypass: the block SHALL return write_data_i on a read port when write_enable_i=1 and write_addr_i equals that port's address, except for register 0 when ZERO_REG=1.
REQ-005 When ZERO_REG=1, a read of address 0 SHALL always return 0, and a write or issue to address 0 SHALL have no effect.
REQ-006 A write SHALL update the array on the rising clock edge when write_enable_i=1.
REQ-007 Scoreboard: each register SHALL have a pending bit; issue_valid_i sets pending[issue_addr_i] and write_enable_i clears pending[write_addr_i], both at the rising edge.
REQ-008 When an issue and a write target the same address in the same cycle, set SHALL win: the new producer stays pending.
REQ-009 busy_x_o SHALL equal pending[read_addr_x] AND NOT (write_enable_i AND write_addr_i == read_addr_x); bypassed data is not busy.
REQ-010 Trap FSM states SHALL be IDLE and TRAP; trap_active_o=1 exactly in state TRAP.
REQ-011 IDLE with trap_i=1: the block SHALL capture trap_pc_i, trap_cause_i and trap_val_i into mepc/mcause/mtval, clear all pending bits, and enter TRAP at the next edge.
- An issue in the same cycle is dropped.
- A write in the same cycle still updates the array.
REQ-012 TRAP with trap_i=0 and mret_i=1: the block SHALL return to IDLE at the next edge; mepc/mcause/mtval hold their values.
REQ-013 TRAP with trap_i=1 (regardless of mret_i): the block SHALL stay in TRAP, leave mepc/mcause/mtval unchanged and set double_fault_o at the next edge.
REQ-014 mret_i in IDLE SHALL be ignored.
REQ-015 double_fault_o SHALL clear only on reset.
REQ-016 Trap register outputs SHALL be registered; a captured value is visible one cycle after the trap_i cycle.

Reset
REQ-017 rsn_i=0 SHALL asynchronously force:
- all array entries to 0;
- all pending bits to 0;
- mepc_o/mcause_o/mtval_o to 0;
- state to IDLE, trap_active_o=0, double_fault_o=0.
REQ-018 While rsn_i=0, all write, issue, trap and mret inputs SHALL be ignored.
REQ-019 A reset asserted mid-trap SHALL return the FSM to IDLE with no capture.
REQ-020 Outputs SHALL take their reset values without waiting for a clock edge.

Verification
REQ-021 Write x5=0xDEADBEEF; next cycle read A=5 -> read_data_a_o=0xDEADBEEF; same-cycle read B=5 during that write -> bypass gives 0xDEADBEEF.
REQ-022 Write x0=0x1234 with ZERO_REG=1, then read A=0 -> 0; issue x0 -> busy_a_o stays 0.
REQ-023 Issue x7, then read A=7 -> busy_a_o=1; write x7 with data 0x55 -> busy_a_o=0 and data 0x55 that cycle; issue x7 and write x7 in the same cycle -> busy_a_o=1 afterwards.
REQ-024 Trap with pc=0x100, cause=0x2, val=0xBAD -> next cycle mepc=0x100, mcause=0x2, mtval=0xBAD, trap_active_o=1, all busy=0; then mret -> trap_active_o=0.
REQ-025 In TRAP, trap with pc=0x200 -> mepc stays 0x100 and double_fault_o=1; then mret and a new trap -> capture 0x200 while double_fault_o stays 1.
REQ-026 Assert rsn_i=0 asynchronously mid-TRAP -> all outputs are 0 immediately without a clock edge; after release, read of any register -> 0.
